alu_op_encoder: RTL and testbench
=================================

Name: alu_op_encoder

Overview:
- Pipelined instruction-to-ALU-control encoder. Accepts RV32I instruction words over a valid/ready handshake.
- Emits one registered control packet per instruction: 4-bit ALU opcode, operand-A select, operand-B select and an illegal flag.
- Sits between instruction fetch and the ALU/execute stage, so it generates the i_alu_op encoding the ALU consumes.
- A 2-entry skid buffer gives full throughput under backpressure. A saturating illegal-instruction counter supports debug.

Parameters:
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- i_clk  input  1  clock; all state updates on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_insn_vld  input  1  instruction valid.
- o_insn_rdy  output  1  encoder can accept an instruction this cycle.
- i_insn  input  32  RV32I instruction word.
- o_dec_vld  output  1  control packet valid.
- i_dec_rdy  input  1  downstream accepts the packet.
- o_alu_op  output  4  ALU opcode.
- o_opa_sel  output  2  operand-A select: 00 rs1, 01 pc, 10 zero.
- o_opb_sel  output  1  operand-B select: 0 rs2, 1 imm.
- o_illegal  output  1  instruction not supported.
- i_cnt_clr  input  1  synchronous clear of the illegal counter.
- o_illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: o_dec_vld=0, skid entry invalid, o_insn_rdy=1 (after reset release), o_alu_op=0000, o_opa_sel=00, o_opb_sel=0, o_illegal=0, o_illegal_cnt=0.
- Reset mid-operation: discards both buffered entries. No packet is emitted after release until a new accept.
- ALU opcode values: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111.
- Encoding, OP (0110011):
  - alu_op = {insn[30], funct3}.
  - insn[30] is legal only when funct3 is 000 or 101.
  - funct7 must be 0000000 or 0100000; anything else is illegal.
  - opa=rs1, opb=rs2.
- Encoding, OP-IMM (0010011):
  - alu_op = {(funct3==101) & insn[30], funct3}, so ADDI never yields SUB.
  - SLLI requires funct7=0000000. SRLI/SRAI require funct7 of 0000000 or 0100000; otherwise illegal.
  - opa=rs1, opb=imm.
- Encoding, other opcodes (all alu_op=ADD, opb=imm):
  - LOAD, STORE, JALR: opa=rs1.
  - BRANCH, JAL, AUIPC: opa=pc.
  - LUI: opa=zero.
- Illegal instructions:
  - Any other opcode, or insn[1:0]!=11, sets illegal=1 with alu_op=0000, opa=00, opb=0.
  - The packet still passes downstream in order.
- Handshake:
  - Accept when i_insn_vld & o_insn_rdy. Emit when o_dec_vld & i_dec_rdy.
  - Latency: exactly 1 cycle from accept to o_dec_vld when downstream is not stalled.
  - Throughput: 1 instruction per cycle.
- Skid buffer rules:
  - o_insn_rdy = !skid_vld, driven from a register with no combinational path from i_dec_rdy.
  - The output register loads when it is empty or being emitted. Source is the skid entry if valid, else the accepted input.
  - If the output register holds an un-emitted packet and an accept occurs, the accepted packet goes to the skid entry.
  - Simultaneous accept and emit with skid valid is impossible, because o_insn_rdy=0 then.
  - Order is always preserved. Output packet fields are stable while o_dec_vld=1 & i_dec_rdy=0.
- Illegal counter:
  - Increments on accept of an illegal instruction and saturates at 2^CNT_W-1.
  - i_cnt_clr has priority over an increment in the same cycle; the result is 0.

Decomposition:
- Package alu_pkg holds:
  - the ALU opcode localparams listed above;
  - RV32I major-opcode constants;
  - operand-select encodings (OPA_RS1, OPA_PC, OPA_ZERO, OPB_RS2, OPB_IMM);
  - a packed struct for the 7-bit control packet.
- One sub-module: skid_buffer, parameterised by WIDTH, implementing the 2-entry valid/ready buffer. The combinational encode function and the counter stay in the top module.

Test Plan:
- Stream sub x3,x1,x2 (0x402081B3) then srai x5,x6,3 (0x40335293), i_dec_rdy=1:
  - packets on consecutive cycles, 1 cycle after each accept;
  - first packet: alu_op 1000, opa 00, opb 0;
  - second packet: alu_op 1101, opa 00, opb 1.
- addi x1,x0,1024 (0x40000093): alu_op 0000 (not 1000), opb 1, illegal 0.
- lui x1,0x12345 (0x123450B7) gives alu_op 0000, opa 10, opb 1. auipc (0x00000097) gives opa 01.
- 0x00000000 then 0x0020F1B3 with a bad funct7 (0x0220F1B3):
  - both packets have illegal=1 and alu_op 0000;
  - o_illegal_cnt=2;
  - i_cnt_clr pulsed together with a third illegal accept gives a count of 0.
- Backpressure: i_dec_rdy=0 while presenting 3 valid instructions back-to-back:
  - 2 are accepted, then o_insn_rdy=0;
  - after i_dec_rdy=1, the 3 packets emerge in order with none lost or duplicated.
- Assert i_rst_n=0 asynchronously mid-clock with both entries full: o_dec_vld drops immediately, and no stale packet appears after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I instruction-to-ALU-control encoder.
// Holds the ALU opcode values consumed by the execute stage, the RV32I
// major-opcode constants, the operand-select encodings and the packed
// control packet that travels from the encoder to the ALU.
package alu_pkg;

  // ALU opcodes: {alt-bit, funct3}, so R-type words map onto them directly
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // RV32I major opcodes (insn[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // Operand selects
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;
  localparam logic       OPB_RS2  = 1'b0;
  localparam logic       OPB_IMM  = 1'b1;

  // 7-bit ALU control packet
  typedef struct packed {
    logic [3:0] aluOp;
    logic [1:0] opaSel;
    logic       opbSel;
  } ctrl_t;

  // What actually flows through the pipeline: control plus illegal flag
  typedef struct packed {
    logic  illegal;
    ctrl_t ctrl;
  } pkt_t;

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready skid buffer.
// Ports:
//   i_clk, i_rst_n      clock, asynchronous active-low reset
//   i_vld/o_rdy/i_data  upstream handshake and payload
//   o_vld/i_rdy/o_data  downstream handshake and registered payload
// o_rdy comes straight from the skid-valid flop, so there is no
// combinational path from i_rdy back to o_rdy.
module skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vld,
  output logic             o_rdy,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  input  logic             i_rdy,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] outData_q, outData_d;
  logic [WIDTH-1:0] skidData_q, skidData_d;
  logic             outVld_q, outVld_d;
  logic             skidVld_q, skidVld_d;
  logic             accept;

  assign o_rdy  = ~skidVld_q;
  assign o_vld  = outVld_q;
  assign o_data = outData_q;
  assign accept = i_vld & ~skidVld_q;

  // The output register refills whenever it is empty or draining. The
  // skid entry always wins because it is older than anything upstream;
  // an accept cannot coincide with a valid skid entry since o_rdy is low.
  always_comb begin
    outData_d  = outData_q;
    outVld_d   = outVld_q;
    skidData_d = skidData_q;
    skidVld_d  = skidVld_q;
    if (!outVld_q || i_rdy) begin
      if (skidVld_q) begin
        outData_d = skidData_q;
        outVld_d  = 1'b1;
        skidVld_d = 1'b0;
      end else begin
        outVld_d = accept;
        if (accept) begin
          outData_d = i_data;
        end
      end
    end else if (accept) begin
      skidData_d = i_data;
      skidVld_d  = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      outData_q  <= '0;
      outVld_q   <= 1'b0;
      skidData_q <= '0;
      skidVld_q  <= 1'b0;
    end else begin
      outData_q  <= outData_d;
      outVld_q   <= outVld_d;
      skidData_q <= skidData_d;
      skidVld_q  <= skidVld_d;
    end
  end

endmodule

// File: rtl/alu_op_encoder.sv
// Pipelined RV32I instruction-to-ALU-control encoder.
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_insn_vld/o_insn_rdy    instruction handshake, i_insn payload
//   o_dec_vld/i_dec_rdy      control-packet handshake
//   o_alu_op, o_opa_sel,
//   o_opb_sel, o_illegal     registered control packet
//   i_cnt_clr, o_illegal_cnt saturating count of accepted illegal words
module alu_op_encoder
  import alu_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_insn_vld,
  output logic             o_insn_rdy,
  input  logic [31:0]      i_insn,
  output logic             o_dec_vld,
  input  logic             i_dec_rdy,
  output logic [3:0]       o_alu_op,
  output logic [1:0]       o_opa_sel,
  output logic             o_opb_sel,
  output logic             o_illegal,
  input  logic             i_cnt_clr,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Illegal words come out as an all-zero control with the flag set.
  function automatic pkt_t encodeInsn(input logic [31:0] insn);
    pkt_t       pkt;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       f7Base;
    logic       f7Alt;
    funct3 = insn[14:12];
    funct7 = insn[31:25];
    f7Base = (funct7 == 7'b0000000);
    f7Alt  = (funct7 == 7'b0100000);
    pkt = '{illegal: 1'b1, ctrl: '{aluOp: ALU_ADD, opaSel: OPA_RS1, opbSel: OPB_RS2}};
    // insn[1:0] != 11 never matches any opcode below, so it lands on the default
    case (insn[6:0])
      OPC_OP: begin
        // insn[30] only selects SUB/SRA; on other funct3 it is undefined
        if (f7Base || (f7Alt && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          pkt.illegal = 1'b0;
          pkt.ctrl    = '{aluOp: {insn[30], funct3}, opaSel: OPA_RS1, opbSel: OPB_RS2};
        end
      end
      OPC_OPIMM: begin
        // For non-shifts insn[30] is immediate data, hence the funct3 gate
        if ((funct3 != 3'b001 || f7Base) && (funct3 != 3'b101 || f7Base || f7Alt)) begin
          pkt.illegal = 1'b0;
          pkt.ctrl    = '{aluOp: {(funct3 == 3'b101) & insn[30], funct3},
                          opaSel: OPA_RS1, opbSel: OPB_IMM};
        end
      end
      OPC_LOAD, OPC_STORE, OPC_JALR: begin
        pkt.illegal = 1'b0;
        pkt.ctrl    = '{aluOp: ALU_ADD, opaSel: OPA_RS1, opbSel: OPB_IMM};
      end
      OPC_BRANCH, OPC_JAL, OPC_AUIPC: begin
        pkt.illegal = 1'b0;
        pkt.ctrl    = '{aluOp: ALU_ADD, opaSel: OPA_PC, opbSel: OPB_IMM};
      end
      OPC_LUI: begin
        pkt.illegal = 1'b0;
        pkt.ctrl    = '{aluOp: ALU_ADD, opaSel: OPA_ZERO, opbSel: OPB_IMM};
      end
      default: ;
    endcase
    return pkt;
  endfunction

  pkt_t             encPkt;
  logic [7:0]       outBits;
  pkt_t             outPkt;
  logic             acceptInsn;
  logic [CNT_W-1:0] illegalCnt_q, illegalCnt_d;

  assign encPkt     = encodeInsn(i_insn);
  assign acceptInsn = i_insn_vld & o_insn_rdy;

  skid_buffer #(
    .WIDTH ($bits(pkt_t))
  ) uSkid (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_vld   (i_insn_vld),
    .o_rdy   (o_insn_rdy),
    .i_data  (encPkt),
    .o_vld   (o_dec_vld),
    .i_rdy   (i_dec_rdy),
    .o_data  (outBits)
  );

  assign outPkt    = pkt_t'(outBits);
  assign o_alu_op  = outPkt.ctrl.aluOp;
  assign o_opa_sel = outPkt.ctrl.opaSel;
  assign o_opb_sel = outPkt.ctrl.opbSel;
  assign o_illegal = outPkt.illegal;

  // Clear beats a same-cycle increment; the count sticks at all-ones.
  always_comb begin
    illegalCnt_d = illegalCnt_q;
    if (i_cnt_clr) begin
      illegalCnt_d = '0;
    end else if (acceptInsn && encPkt.illegal && illegalCnt_q != CNT_MAX) begin
      illegalCnt_d = illegalCnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      illegalCnt_q <= '0;
    end else begin
      illegalCnt_q <= illegalCnt_d;
    end
  end

  assign o_illegal_cnt = illegalCnt_q;

endmodule

// File: tb/tb_alu_op_encoder.sv
// Self-checking bench for alu_op_encoder: directed steps followed by a
// randomized phase, compared against a queue-based reference model.
module tb_alu_op_encoder;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rstN = 1'b0;
  logic             insnVld = 1'b0;
  logic [31:0]      insn = 32'h0;
  logic             decRdy = 1'b0;
  logic             cntClr = 1'b0;
  logic             insnRdy;
  logic             decVld;
  logic [3:0]       aluOp;
  logic [1:0]       opaSel;
  logic             opbSel;
  logic             illegal;
  logic [CNT_W-1:0] illegalCnt;

  int totalChecks = 0;
  int passCount   = 0;
  int failCount   = 0;

  // Expected packets in flight, oldest first: {illegal, aluOp, opa, opb}
  logic [7:0]  expQ[$];
  int unsigned expCnt = 0;

  always #5 clk = ~clk;

  alu_op_encoder #(.CNT_W(CNT_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_insn_vld    (insnVld),
    .o_insn_rdy    (insnRdy),
    .i_insn        (insn),
    .o_dec_vld     (decVld),
    .i_dec_rdy     (decRdy),
    .o_alu_op      (aluOp),
    .o_opa_sel     (opaSel),
    .o_opb_sel     (opbSel),
    .o_illegal     (illegal),
    .i_cnt_clr     (cntClr),
    .o_illegal_cnt (illegalCnt)
  );

  // Reference encoding straight from the RV32I rules
  function automatic logic [7:0] refEncode(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    if (opc == 7'h33) begin
      if (f7 == 7'h00) return {1'b0, 1'b0, f3, 2'd0, 1'b0};
      if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return {1'b0, 1'b1, f3, 2'd0, 1'b0};
      return 8'h80;
    end
    if (opc == 7'h13) begin
      if (f3 == 3'd1 && f7 != 7'h00) return 8'h80;
      if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) return 8'h80;
      return {1'b0, (f3 == 3'd5 && f7 == 7'h20), f3, 2'd0, 1'b1};
    end
    if (opc == 7'h03 || opc == 7'h23 || opc == 7'h67) return 8'b0_0000_00_1;
    if (opc == 7'h63 || opc == 7'h6F || opc == 7'h17) return 8'b0_0000_01_1;
    if (opc == 7'h37) return 8'b0_0000_10_1;
    return 8'h80;
  endfunction

  function automatic logic [31:0] randInsn();
    logic [6:0]  ops[10] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
                             7'h37, 7'h63, 7'h67, 7'h6F, 7'h7F};
    logic [31:0] w;
    int          pick;
    int          f7Pick;
    w    = $urandom;
    pick = $urandom_range(0, 10);
    if (pick < 10) w[6:0] = ops[pick];
    f7Pick = $urandom_range(0, 3);
    if (f7Pick == 0) w[31:25] = 7'h00;
    else if (f7Pick == 1) w[31:25] = 7'h20;
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalChecks++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    check("insn_rdy", {31'd0, insnRdy}, {31'd0, expQ.size() < 2});
    check("dec_vld", {31'd0, decVld}, {31'd0, expQ.size() > 0});
    if (expQ.size() > 0)
      check("packet", {24'd0, illegal, aluOp, opaSel, opbSel}, {24'd0, expQ[0]});
    check("illegal_cnt", {24'd0, illegalCnt}, expCnt);
  endtask

  // One clock: drive, check at the falling edge, update the model at the rising edge
  task automatic applyStimulus(input logic vld, input logic [31:0] w,
                               input logic rdy, input logic clr);
    logic       accept;
    logic       emit;
    logic [7:0] pkt;
    insnVld = vld;
    insn    = w;
    decRdy  = rdy;
    cntClr  = clr;
    pkt     = refEncode(w);
    @(negedge clk);
    checkOutput();
    accept = vld && (expQ.size() < 2);
    emit   = rdy && (expQ.size() > 0);
    @(posedge clk);
    if (emit) void'(expQ.pop_front());
    if (accept) expQ.push_back(pkt);
    if (clr) expCnt = 0;
    else if (accept && pkt[7] && expCnt < (2 ** CNT_W - 1)) expCnt++;
    #1;
  endtask

  initial begin
    #12;
    check("rst_vld", {31'd0, decVld}, 32'd0);
    check("rst_op", {28'd0, aluOp}, 32'd0);
    check("rst_opa", {30'd0, opaSel}, 32'd0);
    check("rst_opb_ill", {30'd0, opbSel, illegal}, 32'd0);
    check("rst_cnt", {24'd0, illegalCnt}, 32'd0);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rdy", {31'd0, insnRdy}, 32'd1);

    applyStimulus(1'b1, 32'h402081B3, 1'b1, 1'b0);
    check("sub_vld", {31'd0, decVld}, 32'd1);
    check("sub_op", {28'd0, aluOp}, 32'b1000);
    check("sub_sel", {29'd0, opaSel, opbSel}, 32'b000);
    applyStimulus(1'b1, 32'h40335293, 1'b1, 1'b0);
    check("srai_vld", {31'd0, decVld}, 32'd1);
    check("srai_op", {28'd0, aluOp}, 32'b1101);
    check("srai_sel", {29'd0, opaSel, opbSel}, 32'b001);
    applyStimulus(1'b1, 32'h40000093, 1'b1, 1'b0);
    check("addi_op", {28'd0, aluOp}, 32'b0000);
    check("addi_opb_ill", {30'd0, opbSel, illegal}, 32'b10);
    applyStimulus(1'b1, 32'h123450B7, 1'b1, 1'b0);
    check("lui_sel", {25'd0, aluOp, opaSel, opbSel}, 32'b0000_10_1);
    applyStimulus(1'b1, 32'h00000097, 1'b1, 1'b0);
    check("auipc_opa", {30'd0, opaSel}, 32'b01);
    applyStimulus(1'b1, 32'h00000000, 1'b1, 1'b0);
    check("zero_ill", {27'd0, illegal, aluOp}, 32'b1_0000);
    applyStimulus(1'b1, 32'h0220F1B3, 1'b1, 1'b0);
    check("badf7_ill", {27'd0, illegal, aluOp}, 32'b1_0000);
    check("cnt_two", {24'd0, illegalCnt}, 32'd2);
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 1'b1);
    check("cnt_clr_prio", {24'd0, illegalCnt}, 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Backpressure: three back-to-back words, only two fit
    applyStimulus(1'b1, 32'h00A50533, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h40B50533, 1'b0, 1'b0);
    check("bp_full_rdy", {31'd0, insnRdy}, 32'd0);
    applyStimulus(1'b1, 32'h00B57533, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h00B57533, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h00B57533, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Saturation of the illegal counter
    for (int i = 0; i < 2 ** CNT_W + 4; i++) applyStimulus(1'b1, 32'h0000007F, 1'b1, 1'b0);
    check("cnt_sat", {24'd0, illegalCnt}, 32'd255);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 3) != 0, randInsn(), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 15) == 0);

    // Asynchronous reset with both entries occupied
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h402081B3, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h0000007F, 1'b0, 1'b0);
    check("pre_rst_full", {30'd0, decVld, insnRdy}, 32'b10);
    insnVld = 1'b0;
    #2;
    rstN = 1'b0;
    #1;
    check("async_rst_vld", {31'd0, decVld}, 32'd0);
    check("async_rst_cnt", {24'd0, illegalCnt}, 32'd0);
    expQ.delete();
    expCnt = 0;
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    check("post_rst_vld", {31'd0, decVld}, 32'd0);

    $display("%0d/%0d checks passed", passCount, totalChecks);
    $finish;
  end

endmodule
